// File: rtl/mux_scan_ctrl_pkg.sv
// Shared definitions for the mux scan sequencer: FSM state encoding and default sizes.
// No logic here; pure types and constants.
// Imported by the sequencer top and its channel-finder helper.
package mux_scan_ctrl_pkg;

    localparam int WIDTH_DEF  = 4;
    localparam int SWIDTH_DEF = 3;
    localparam int NCH_DEF    = 1 << SWIDTH_DEF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Downstream beat bus of the scan sequencer: (channel, data) on valid/ready.
// No latency of its own; pure wiring bundle.
// Producer holds m_data/m_ch/m_valid stable while m_ready is low.
interface mux_scan_ctrl_if #(
    parameter int width  = 4,
    parameter int swidth = 3
);
    logic [width-1:0]  m_data;
    logic [swidth-1:0] m_ch;
    logic              m_valid;
    logic              m_ready;

    modport master (output m_data, output m_ch, output m_valid, input m_ready);
    modport slave  (input m_data, input m_ch, input m_valid, output m_ready);
endinterface

// File: rtl/mux_scan_ctrl_next_ch_find.sv
// Finds the lowest set mask bit above cur, and the lowest set mask bit overall.
// Purely combinational, zero cycles.
// No handshake; outputs follow inputs.
module next_ch_find #(
    parameter int swidth = 3,
    parameter int NCH    = 1 << swidth
) (
    input  logic [NCH-1:0]    mask,
    input  logic [swidth-1:0] cur,
    output logic [swidth-1:0] nxt,
    output logic              nxt_found,
    output logic [swidth-1:0] first,
    output logic              first_found
);

    // Scan from the top down so the last hit is the lowest qualifying bit.
    always_comb begin
        nxt         = '0;
        nxt_found   = 1'b0;
        first       = '0;
        first_found = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                first       = swidth'(i);
                first_found = 1'b1;
                if (i > int'(cur)) begin
                    nxt       = swidth'(i);
                    nxt_found = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Steps the 8:1 mux select over enabled channels and emits each word as a (ch, data) beat.
// start -> sel valid next cycle -> m_valid the cycle after; 1 beat per 2 cycles at full rate.
// Beat and select are frozen in HOLD until m_ready; no beat is ever dropped except on rst.
module mux_scan_ctrl
    import mux_scan_ctrl_pkg::*;
#(
    parameter int width  = WIDTH_DEF,
    parameter int swidth = SWIDTH_DEF,
    parameter int NCH    = 1 << swidth
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cont,
    input  logic [NCH-1:0]    en_mask,
    output logic [swidth-1:0] sel,
    input  logic [width-1:0]  mux_o,
    output logic              busy,
    output logic              done,
    mux_scan_ctrl_if.master   m
);

    state_t            state;
    logic [NCH-1:0]    mask_q;
    logic [NCH-1:0]    find_mask;
    logic [width-1:0]  data_q;
    logic [swidth-1:0] ch_q;
    logic              valid_q;
    logic [swidth-1:0] nxt;
    logic [swidth-1:0] first;
    logic              nxt_found;
    logic              first_found;

    // In IDLE the first channel must come from the live mask, since mask_q is only loaded on start.
    assign find_mask = (state == IDLE) ? en_mask : mask_q;

    next_ch_find #(.swidth(swidth), .NCH(NCH)) u_find (
        .mask        (find_mask),
        .cur         (sel),
        .nxt         (nxt),
        .nxt_found   (nxt_found),
        .first       (first),
        .first_found (first_found)
    );

    assign busy      = (state != IDLE);
    assign m.m_data  = data_q;
    assign m.m_ch    = ch_q;
    assign m.m_valid = valid_q;

    // Scan FSM with registered select, beat and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sel     <= '0;
            data_q  <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            done    <= 1'b0;
            mask_q  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mask_q <= en_mask;
                        if (first_found) begin
                            sel   <= first;
                            state <= SETTLE;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    data_q  <= mux_o;
                    ch_q    <= sel;
                    valid_q <= 1'b1;
                    state   <= HOLD;
                end
                HOLD: begin
                    if (m.m_ready) begin
                        valid_q <= 1'b0;
                        if (nxt_found) begin
                            sel   <= nxt;
                            state <= SETTLE;
                        end else if (cont) begin
                            sel   <= first;
                            state <= SETTLE;
                        end else begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl driving a behavioural 8:1 mux with inputs 1..8.
// Inputs driven and outputs sampled on the falling edge.
// Summary line reports compared/mismatched counts.
module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       cont;
    logic [7:0] en_mask;
    logic [2:0] sel;
    logic [3:0] mux_o;
    logic       busy;
    logic       done;
    logic       m_ready;

    logic [3:0] mux_in [8];
    int n_cmp = 0;
    int n_err = 0;

    logic [2:0] q_ch[$];
    logic [3:0] q_dat[$];
    logic       done_seen;

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 8; i++) mux_in[i] = 4'(i + 1);
    end
    assign mux_o = mux_in[sel];

    mux_scan_ctrl_if #(.width(4), .swidth(3)) mif ();
    assign mif.m_ready = m_ready;

    mux_scan_ctrl #(.width(4), .swidth(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .cont    (cont),
        .en_mask (en_mask),
        .sel     (sel),
        .mux_o   (mux_o),
        .busy    (busy),
        .done    (done),
        .m       (mif.master)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; records beats until done or the budget runs out.
    task automatic collect(input int budget);
        q_ch.delete();
        q_dat.delete();
        done_seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (mif.m_valid && m_ready) begin
                q_ch.push_back(mif.m_ch);
                q_dat.push_back(mif.m_data);
            end
            if (done) begin
                done_seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int beats;
        logic found;
        logic [2:0] e2_ch [3];
        logic [3:0] e2_dat [3];
        e2_ch  = '{3'd2, 3'd5, 3'd7};
        e2_dat = '{4'd3, 4'd6, 4'd8};

        rst = 1'b1; start = 1'b0; cont = 1'b0; en_mask = 8'h00; m_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_val("rst_sel", sel, 0);
        check_val("rst_valid", mif.m_valid, 0);
        check_val("rst_data", mif.m_data, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: full mask, single pass, full rate
        en_mask = 8'hFF; cont = 1'b0; m_ready = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        check_val("t1_sel_t1", sel, 0);
        check_val("t1_valid_t1", mif.m_valid, 0);
        check_val("t1_busy_t1", busy, 1);
        @(negedge clk);
        check_val("t1_valid_t2", mif.m_valid, 1);
        check_val("t1_ch0", mif.m_ch, 0);
        check_val("t1_dat0", mif.m_data, 1);
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            check_val("t1_gap", mif.m_valid, 0);
            @(negedge clk);
            check_val("t1_valid", mif.m_valid, 1);
            check_val("t1_ch", mif.m_ch, k);
            check_val("t1_dat", mif.m_data, k + 1);
        end
        @(negedge clk);
        check_val("t1_done", done, 1);
        check_val("t1_busy_end", busy, 0);
        check_val("t1_valid_end", mif.m_valid, 0);
        @(negedge clk);
        check_val("t1_done_pulse", done, 0);

        // 2: sparse mask
        en_mask = 8'b1010_0100; start = 1'b1;
        @(negedge clk); start = 1'b0;
        collect(60);
        check_val("t2_done", done_seen, 1);
        check_val("t2_busy", busy, 0);
        check_val("t2_nbeats", q_ch.size(), 3);
        for (int k = 0; k < 3 && k < q_ch.size(); k++) begin
            check_val("t2_ch", q_ch[k], e2_ch[k]);
            check_val("t2_dat", q_dat[k], e2_dat[k]);
        end
        @(negedge clk);

        // 3: backpressure on ch1
        en_mask = 8'hFF; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        check_val("t3_ch0", mif.m_ch, 0);
        @(negedge clk);
        m_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_val("t3_hold_valid", mif.m_valid, 1);
            check_val("t3_hold_dat", mif.m_data, 2);
            check_val("t3_hold_ch", mif.m_ch, 1);
            check_val("t3_hold_sel", sel, 1);
        end
        m_ready = 1'b1;
        collect(60);
        check_val("t3_done", done_seen, 1);
        check_val("t3_nbeats", q_ch.size(), 7);
        for (int k = 0; k < 7 && k < q_ch.size(); k++) begin
            check_val("t3_ch", q_ch[k], k + 1);
            check_val("t3_dat", q_dat[k], k + 2);
        end
        @(negedge clk);

        // 4: empty mask
        en_mask = 8'h00; start = 1'b1;
        @(negedge clk); start = 1'b0;
        check_val("t4_done", done, 1);
        check_val("t4_busy", busy, 0);
        check_val("t4_valid", mif.m_valid, 0);
        @(negedge clk);
        check_val("t4_done_pulse", done, 0);
        check_val("t4_busy2", busy, 0);
        check_val("t4_valid2", mif.m_valid, 0);

        // 5: continuous scan over ch0/ch7, stopped by dropping cont
        en_mask = 8'h81; cont = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        beats = 0; done_seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (mif.m_valid) begin
                check_val("t5_ch", mif.m_ch, (beats % 2 == 1) ? 7 : 0);
                beats++;
                if (beats == 4) cont = 1'b0;
            end
            if (done) begin
                done_seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_val("t5_beats", beats, 4);
        check_val("t5_done", done_seen, 1);
        check_val("t5_busy", busy, 0);
        @(negedge clk);

        // 6: start while busy is ignored, then reset mid-HOLD at ch4
        en_mask = 8'hFF; cont = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (mif.m_valid && mif.m_ch == 3'd2) begin
                start = 1'b1;
                en_mask = 8'h01;
            end else begin
                start = 1'b0;
            end
            if (mif.m_valid && mif.m_ch == 3'd4) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_val("t6_reach_ch4", found, 1);
        check_val("t6_sel4", sel, 4);
        check_val("t6_dat4", mif.m_data, 5);
        rst = 1'b1;
        @(negedge clk);
        check_val("t6_rst_sel", sel, 0);
        check_val("t6_rst_valid", mif.m_valid, 0);
        check_val("t6_rst_data", mif.m_data, 0);
        check_val("t6_rst_ch", mif.m_ch, 0);
        check_val("t6_rst_busy", busy, 0);
        check_val("t6_rst_done", done, 0);
        rst = 1'b0;
        @(negedge clk);
        check_val("t6_idle_valid", mif.m_valid, 0);
        check_val("t6_idle_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
